// File: rtl/mult4_prod_accum.sv
// Purpose: sums FRAME_LEN unsigned 8-bit multiplier products per frame and reports the sum with an overflow flag.
// Latency: out_valid rises on the edge after the frame's last product is accepted; in_ready returns the edge after the output transfer.
// Backpressure: while a finished frame is held (out_ready low) in_ready stays low and no further products are absorbed.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   product handshake, in_prod = 8-bit unsigned product
//   out_valid/out_ready frame-result handshake
//   out_sum             ACC_W-bit frame sum (registered)
//   out_ovf             set when the running sum carried out of ACC_W bits during the frame
//
// Build option: define MULT4_ACC_SAT_EN to saturate the accumulator at 2^ACC_W-1 on carry
// instead of wrapping modulo 2^ACC_W. out_ovf behaves the same in both builds.

module mult4_prod_accum #(
  parameter int FRAME_LEN = 4,   // products per frame, 1..255
  parameter int ACC_W     = 16   // accumulator width, 8..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic             accept;
  logic             out_xfer;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  assign accept   = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Add one bit of headroom so the carry out of the accumulator is visible.
  always_comb begin
    sum_ext  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, in_prod};
    carry    = sum_ext[ACC_W];
`ifdef MULT4_ACC_SAT_EN
    // Once saturated, any further nonzero product carries again, so the
    // accumulator stays pinned at all-ones for the rest of the frame.
    acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
  end

  // in_ready/out_valid are kept as flops alongside the state so the
  // handshake outputs come straight from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            ovf <= ovf | carry;
            if (cnt == LAST_CNT) begin
              cnt       <= '0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          // No release-and-accept in the same cycle: in_ready comes back
          // only after the transfer edge.
          if (out_xfer) begin
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule
